// File: rtl/mod_sched_pkg.sv
// Shared types and constants for the SHA-2 message-schedule expander.
// Holds the FSM state encoding, the small-sigma rotate/shift amounts for
// both word widths, and parameter legality helpers.
package mod_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  // SHA-256 small sigmas (32-bit words)
  localparam int S0_ROT_A_32 = 7;
  localparam int S0_ROT_B_32 = 18;
  localparam int S0_SHR_32   = 3;
  localparam int S1_ROT_A_32 = 17;
  localparam int S1_ROT_B_32 = 19;
  localparam int S1_SHR_32   = 10;

  // SHA-512 small sigmas (64-bit words)
  localparam int S0_ROT_A_64 = 1;
  localparam int S0_ROT_B_64 = 8;
  localparam int S0_SHR_64   = 7;
  localparam int S1_ROT_A_64 = 19;
  localparam int S1_ROT_B_64 = 61;
  localparam int S1_SHR_64   = 6;

  // Schedule length must cover the 16 message words and at most SHA-512's 80.
  function automatic bit rounds_legal(input int rounds);
    return (rounds >= 16) && (rounds <= 80);
  endfunction

  // Only the two SHA-2 word widths have defined sigma constants.
  function automatic bit width_legal(input int word_w);
    return (word_w == 32) || (word_w == 64);
  endfunction

endpackage

// File: rtl/mod_sigma.sv
// Small-sigma function of the SHA-2 message schedule.
// SEL=0 gives sigma0, SEL=1 gives sigma1; WORD_W selects the SHA-256 (32)
// or SHA-512 (64) rotate/shift amounts. Purely combinational.
module mod_sigma
  import mod_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL    = 0
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  localparam int ROT_A = (WORD_W == 64) ? ((SEL == 1) ? S1_ROT_A_64 : S0_ROT_A_64)
                                        : ((SEL == 1) ? S1_ROT_A_32 : S0_ROT_A_32);
  localparam int ROT_B = (WORD_W == 64) ? ((SEL == 1) ? S1_ROT_B_64 : S0_ROT_B_64)
                                        : ((SEL == 1) ? S1_ROT_B_32 : S0_ROT_B_32);
  localparam int SHR_N = (WORD_W == 64) ? ((SEL == 1) ? S1_SHR_64 : S0_SHR_64)
                                        : ((SEL == 1) ? S1_SHR_32 : S0_SHR_32);

  logic [WORD_W-1:0] rot_a;
  logic [WORD_W-1:0] rot_b;
  logic [WORD_W-1:0] shr_c;

  // Two rotations and one logical shift, XORed together.
  always_comb begin
    rot_a = (x_i >> ROT_A) | (x_i << (WORD_W - ROT_A));
    rot_b = (x_i >> ROT_B) | (x_i << (WORD_W - ROT_B));
    shr_c = x_i >> SHR_N;
    y_o   = rot_a ^ rot_b ^ shr_c;
  end

endmodule

// File: rtl/mod_schedule.sv
// SHA-2 message-schedule expander.
// Loads one 16-word block (M0 first) into a 16-entry shift buffer, then
// streams W[0..ROUNDS-1] from buf[0]. Each output handshake shifts the
// buffer down and refills buf[15] with the next schedule word computed
// combinationally from the registered buffer, so the stream has no bubbles.
// Optional feature macro: MOD_SCHED_ABORT_EN adds an ABORT input that
// forces the block back to IDLE, overriding any same-cycle handshake.
//
// Handshakes: a word moves on a clock edge where valid and ready are both
// high; valid never depends on ready, and the producer holds its data
// stable while valid is high and ready is low.
module mod_schedule
  import mod_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MOD_SCHED_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [6:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output state_e            dbg_state
);

  if (!width_legal(WORD_W)) begin : g_bad_width
    $error("mod_schedule: WORD_W must be 32 or 64");
  end
  if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
    $error("mod_schedule: ROUNDS must be in 16..80");
  end

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        t_q, t_d;
  logic [WORD_W-1:0] sbuf_q [16];
  logic [WORD_W-1:0] sbuf_d [16];

  logic [WORD_W-1:0] s0_y;
  logic [WORD_W-1:0] s1_y;
  logic [WORD_W-1:0] next_w;
  logic              abort_w;

`ifdef MOD_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // sigma0 looks at W[t+1], sigma1 at W[t+14], relative to buf[0] = W[t].
  mod_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
    .x_i (sbuf_q[1]),
    .y_o (s0_y)
  );

  mod_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
    .x_i (sbuf_q[14]),
    .y_o (s1_y)
  );

  // W[t+16]; the sum wraps modulo 2^WORD_W by construction.
  assign next_w = s1_y + sbuf_q[9] + s0_y + sbuf_q[0];

  // Next-state logic: FSM transitions, load counter, round index and buffer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    sbuf_d  = sbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < 15; i++) sbuf_d[i] = sbuf_q[i+1];
          sbuf_d[15] = in_word;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_EXPAND;
            t_d     = '0;
          end
        end
      end
      ST_EXPAND: begin
        if (out_ready) begin
          for (int i = 0; i < 15; i++) sbuf_d[i] = sbuf_q[i+1];
          sbuf_d[15] = next_w;
          t_d        = t_q + 7'd1;
          if (t_q == LAST_IDX) begin
            state_d = ST_IDLE;
            t_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort discards whatever handshake happened in the same cycle.
    if (abort_w) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      t_d     = '0;
      sbuf_d  = sbuf_q;
    end
  end

  // State, counters and shift buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) sbuf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) sbuf_q[i] <= sbuf_d[i];
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_EXPAND);
  assign out_word  = sbuf_q[0];
  assign out_idx   = t_q;
  assign out_last  = out_valid && (t_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mod_schedule.sv
// Directed bench for mod_schedule: a 32-bit/64-round instance and a
// 64-bit/80-round instance share stimulus; a select picks which one the
// driver tasks talk to. Expected streams come from a reference schedule
// model; spot values are hand-computed constants.
module tb_mod_schedule;
  import mod_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic        sel = 1'b0;
  logic        start_m = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_word = '0;
`ifdef MOD_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic        start32, start64;
  logic        in_ready32, out_valid32, out_last32, busy32;
  logic [31:0] out_word32;
  logic [6:0]  out_idx32;
  state_e      dbg32;
  logic        in_ready64, out_valid64, out_last64, busy64;
  logic [63:0] out_word64;
  logic [6:0]  out_idx64;
  state_e      dbg64;

  assign start32 = start_m & ~sel;
  assign start64 = start_m & sel;

  mod_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MOD_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .start     (start32),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .in_word   (in_word[31:0]),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .out_word  (out_word32),
    .out_idx   (out_idx32),
    .out_last  (out_last32),
    .busy      (busy32),
    .dbg_state (dbg32)
  );

  mod_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MOD_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .start     (start64),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .in_word   (in_word),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .out_word  (out_word64),
    .out_idx   (out_idx64),
    .out_last  (out_last64),
    .busy      (busy64),
    .dbg_state (dbg64)
  );

  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [63:0] out_word_m;
  logic [6:0]  out_idx_m;
  state_e      dbg_m;
  assign in_ready_m  = sel ? in_ready64  : in_ready32;
  assign out_valid_m = sel ? out_valid64 : out_valid32;
  assign out_last_m  = sel ? out_last64  : out_last32;
  assign busy_m      = sel ? busy64      : busy32;
  assign out_word_m  = sel ? out_word64  : {32'h0, out_word32};
  assign out_idx_m   = sel ? out_idx64   : out_idx32;
  assign dbg_m       = sel ? dbg64       : dbg32;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] blk[16];
  logic [63:0] cap[80];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference small sigmas written as slices of a doubled word.
  function automatic logic [63:0] ssig(input bit w64, input bit one, input logic [63:0] x);
    logic [63:0]  d32;
    logic [127:0] d64;
    logic [31:0]  r32;
    logic [63:0]  r;
    d32 = {x[31:0], x[31:0]};
    d64 = {x, x};
    if (w64) begin
      if (one) r = d64[82:19] ^ d64[124:61] ^ (x >> 6);
      else     r = d64[64:1]  ^ d64[71:8]   ^ (x >> 7);
    end else begin
      if (one) r32 = d32[48:17] ^ d32[50:19] ^ (x[31:0] >> 10);
      else     r32 = d32[38:7]  ^ d32[49:18] ^ (x[31:0] >> 3);
      r = {32'h0, r32};
    end
    return r;
  endfunction

  task automatic build_exp(input bit w64);
    logic [63:0] w[80];
    logic [63:0] mask;
    int rounds;
    rounds = w64 ? 80 : 64;
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    exp_q.delete();
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) w[t] = blk[t] & mask;
      else w[t] = (ssig(w64, 1'b1, w[t-2]) + w[t-7] + ssig(w64, 1'b0, w[t-15]) + w[t-16]) & mask;
      exp_q.push_back(w[t]);
    end
  endtask

  task automatic set_blk(input logic [63:0] m0, input logic [63:0] fill, input logic [63:0] m15);
    blk[0] = m0;
    for (int i = 1; i < 15; i++) blk[i] = fill;
    blk[15] = m15;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_block();
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check("in_ready_after_start", 64'(in_ready_m), 64'd1);
    check("busy_after_start", 64'(busy_m), 64'd1);
  endtask

  task automatic load_block(input bit gaps, input bit poke);
    int i;
    int guard;
    logic rdy;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 400) begin
      guard++;
      in_word  = blk[i];
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      start_m  = poke && (i == 5);
      rdy      = in_ready_m;
      @(negedge clk);
      if (in_valid && rdy) i++;
    end
    in_valid = 1'b0;
    start_m  = 1'b0;
    if (i < 16) check("load_timeout", 64'(i), 64'd16);
  endtask

  task automatic drain(input bit gaps, input bit poke, input int stop_idx, output bit stopped);
    int n;
    int guard;
    int rounds;
    bit done;
    logic rdy;
    n = 0;
    guard = 0;
    done = 1'b0;
    stopped = 1'b0;
    rounds = sel ? 80 : 64;
    while (!done && !stopped && guard < 2000) begin
      guard++;
      check("out_valid", 64'(out_valid_m), 64'd1);
      check("out_idx", 64'(out_idx_m), 64'(n));
      check("out_last", 64'(out_last_m), 64'(n == rounds - 1));
      if (exp_q.size() == 0) check("exp_underflow", 64'd1, 64'd0);
      else check("out_word", out_word_m, exp_q[0]);
      if (n == stop_idx) begin
        stopped = 1'b1;
      end else begin
        start_m   = poke && (n == 10);
        out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        rdy       = out_ready && out_valid_m;
        if (n < 80) cap[n] = out_word_m;
        @(negedge clk);
        if (rdy) begin
          if (n == rounds - 1) done = 1'b1;
          n++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
    start_m = 1'b0;
    if (done) begin
      out_ready = 1'b0;
      check("idle_valid_after_last", 64'(out_valid_m), 64'd0);
      check("idle_busy_after_last", 64'(busy_m), 64'd0);
      check("idle_state_after_last", 64'(dbg_m), 64'(ST_IDLE));
    end else if (!stopped) begin
      check("drain_timeout", 64'(n), 64'(rounds));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          w64;
    logic [63:0] m0;
    logic [63:0] fill;
    logic [63:0] m15;
    int          idx;
    logic [63:0] exp;
    bit          gaps;
    bit          poke;
  } vec_t;

  function automatic vec_t mk(input bit w64, input logic [63:0] m0, input logic [63:0] fill,
                              input logic [63:0] m15, input int idx, input logic [63:0] exp,
                              input bit gaps, input bit poke);
    vec_t v;
    v.w64 = w64; v.m0 = m0; v.fill = fill; v.m15 = m15;
    v.idx = idx; v.exp = exp; v.gaps = gaps; v.poke = poke;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    bit stopped;

    // Reset values, observed while reset is held.
    #1;
    check("rst_in_ready32", 64'(in_ready32), 64'd0);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_word32", 64'(out_word32), 64'd0);
    check("rst_out_idx32", 64'(out_idx32), 64'd0);
    check("rst_out_last32", 64'(out_last32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_out_word64", out_word64, 64'd0);
    check("rst_busy64", 64'(busy64), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IN_VALID while IDLE must not start anything.
    in_valid = 1'b1;
    in_word  = 64'h0000_0000_DEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready32), 64'd0);
      check("idle_busy", 64'(busy32), 64'd0);
    end
    in_valid = 1'b0;

    vecs[0] = mk(1'b0, 64'h61626380, 64'h0, 64'h18, 0,  64'h61626380, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 64'h61626380, 64'h0, 64'h18, 15, 64'h00000018, 1'b1, 1'b0);
    vecs[2] = mk(1'b0, 64'h61626380, 64'h0, 64'h18, 16, 64'h61626380, 1'b0, 1'b1);
    vecs[3] = mk(1'b0, 64'h61626380, 64'h0, 64'h18, 17, 64'h000F0000, 1'b1, 1'b1);
    vecs[4] = mk(1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 16, 64'h203FFFFC, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 0,  64'hFFFFFFFF, 1'b1, 1'b0);
    vecs[6] = mk(1'b1, 64'h6162638000000000, 64'h0, 64'h18, 16, 64'h6162638000000000, 1'b0, 1'b0);
    vecs[7] = mk(1'b1, 64'h6162638000000000, 64'h0, 64'h18, 17, 64'h00030000000000C0, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      sel = vecs[k].w64;
      set_blk(vecs[k].m0, vecs[k].fill, vecs[k].m15);
      build_exp(vecs[k].w64);
      start_block();
      load_block(vecs[k].gaps, vecs[k].poke);
      drain(vecs[k].gaps, vecs[k].poke, -1, stopped);
      check($sformatf("vec%0d_w%0d", k, vecs[k].idx), cap[vecs[k].idx], vecs[k].exp);
    end

    // Asynchronous reset in the middle of the expansion, then a clean block.
    sel = 1'b0;
    set_blk(64'h61626380, 64'h0, 64'h18);
    build_exp(1'b0);
    start_block();
    load_block(1'b0, 1'b0);
    drain(1'b0, 1'b0, 30, stopped);
    check("stopped_at_30", 64'(stopped), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid32), 64'd0);
    check("async_rst_in_ready", 64'(in_ready32), 64'd0);
    check("async_rst_busy", 64'(busy32), 64'd0);
    check("async_rst_out_word", 64'(out_word32), 64'd0);
    check("async_rst_out_idx", 64'(out_idx32), 64'd0);
    check("async_rst_out_last", 64'(out_last32), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_exp(1'b0);
    start_block();
    load_block(1'b1, 1'b0);
    drain(1'b1, 1'b0, -1, stopped);
    check("post_rst_w17", cap[17], 64'h000F0000);

`ifdef MOD_SCHED_ABORT_EN
    // ABORT during the 64-bit expansion wins over the output handshake.
    sel = 1'b1;
    set_blk(64'h6162638000000000, 64'h0, 64'h18);
    build_exp(1'b1);
    start_block();
    load_block(1'b0, 1'b0);
    drain(1'b0, 1'b0, 40, stopped);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abort_out_valid", 64'(out_valid_m), 64'd0);
    check("abort_in_ready", 64'(in_ready_m), 64'd0);
    check("abort_busy", 64'(busy_m), 64'd0);
    check("abort_out_idx", 64'(out_idx_m), 64'd0);
    // ABORT with START in IDLE stays in IDLE.
    start_m = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    abort   = 1'b0;
    check("abort_start_busy", 64'(busy_m), 64'd0);
    build_exp(1'b1);
    start_block();
    load_block(1'b0, 1'b0);
    drain(1'b0, 1'b0, -1, stopped);
    check("post_abort_w17", cap[17], 64'h00030000000000C0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit so the run always ends with a summary.
  initial begin
    #2_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_schedule.md
# mod_schedule

Parametrised SHA-2 message-schedule expander. Accepts one 16-word message block over a valid/ready input, then streams the full schedule W[0..ROUNDS-1] over a valid/ready output. It uses a 16-entry shift buffer and the small-sigma functions, generalised from 32-bit sigma1 to both sigmas at either word width. It sits between the padding/block-formatter and the compression round engine.

## Interface
- WORD_W, 32: word width; 32 selects SHA-256 constants, 64 selects SHA-512 constants; other values illegal (elaboration error).
- ROUNDS, 64: schedule length; legal range 16..80; use 80 for SHA-512.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  begin new block; honoured only in IDLE.
- IN_VALID  in  1  IN_WORD valid.
- IN_READY  out  1  block accepts a message word.
- IN_WORD  in  WORD_W  message word, M0 first.
- OUT_VALID  out  1  OUT_WORD valid.
- OUT_READY  in  1  consumer accepts OUT_WORD.
- OUT_WORD  out  WORD_W  schedule word W[OUT_IDX].
- OUT_IDX  out  7  index t of OUT_WORD.
- OUT_LAST  out  1  high with OUT_VALID when OUT_IDX = ROUNDS-1.
- BUSY  out  1  high in LOAD or EXPAND.

## Operation
- States: IDLE, LOAD, EXPAND.
- IDLE: IN_READY=0, OUT_VALID=0. START=1 moves the block to LOAD and clears the load counter.
- LOAD: IN_READY=1. Each IN_VALID&IN_READY handshake shifts IN_WORD into buf[15]. Existing entries shift down one place, buf[i] takes buf[i+1]. After the 16th handshake, M0 sits in buf[0] and the block moves to EXPAND with t=0.
- EXPAND: OUT_VALID=1, OUT_WORD=buf[0], OUT_IDX=t. On an OUT handshake the buffer shifts down one place and t increments.
  - buf[15] takes s1(buf[14]) + buf[9] + s0(buf[1]) + buf[0], modulo 2^WORD_W.
  - Indexing matches W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t] for every t.
- Sigma functions:
  - 32-bit: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - 64-bit: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- Handshake on OUT_LAST returns the block to IDLE.
- Boundaries:
  - START outside IDLE is ignored.
  - IN_VALID outside LOAD is ignored.
  - OUT_READY low holds OUT_WORD, OUT_IDX and OUT_LAST stable.
  - Addition wraps silently; there is no carry output.

## Timing
- Reset values: state IDLE, buffer all-zero, t=0. Outputs: IN_READY=0, OUT_VALID=0, OUT_WORD=0, OUT_IDX=0, OUT_LAST=0, BUSY=0.
- START is sampled in IDLE at edge k. IN_READY and BUSY go high after edge k.
- The 16th IN handshake is at edge j. OUT_VALID is high with W[0] after edge j.
- With OUT_READY held high, one word is emitted per cycle, and W[ROUNDS-1] is emitted ROUNDS-1 cycles after W[0].
- Zero-bubble throughput: the sigma and add path is combinational from registered buf into buf[15] only.
- After the OUT_LAST handshake, OUT_VALID and BUSY drop in the next cycle. START can be honoured one cycle after that, in IDLE.
- RST_N asserted mid-operation asynchronously restores all reset values, and any partial block is discarded.

## Configuration
- MOD_SCHED_ABORT_EN defined: adds input ABORT (1 bit).
  - ABORT=1 at any edge forces IDLE and clears t and the load counter.
  - OUT_VALID, IN_READY and BUSY are 0 from the next cycle.
  - ABORT has priority over a simultaneous handshake, and that handshake counts as not taken.
  - ABORT together with START in IDLE leaves the block in IDLE.
- Undefined: no ABORT port; a block in progress can only be terminated by RST_N.

## Structure
- Package mod_sched_pkg:
  - state enum.
  - Rotation and shift constants for both widths.
  - Function computing ROUNDS legality.
- Sub-module mod_sigma, parameters WORD_W and SEL (0=s0, 1=s1). It is purely combinational and instantiated twice; its 32-bit SEL=1 instance is bit-identical to the existing sigma1 module.
- Top level holds the FSM, counters and shift buffer.

## Test plan
- SHA-256 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with OUT_READY=1: W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000. W[63] matches the golden model, OUT_LAST is high only at OUT_IDX=63, and the block returns to IDLE.
- Wrap check, 32-bit, all sixteen words 0xFFFFFFFF: W[16]=0x203FFFFC. This also exercises sigma1 on all-ones, which yields 0x003FFFFF.
- Backpressure with random OUT_READY and IN_VALID gaps: the output stream is identical to the unstalled run, and OUT_WORD and OUT_IDX are stable while stalled.
- START pulsed during LOAD and during EXPAND: ignored, and the index sequence is uninterrupted.
- RST_N pulsed at OUT_IDX=30: all outputs reach reset values asynchronously, and a new START and block then produce the correct W[0..63].
- WORD_W=64, ROUNDS=80 with the SHA-512 "abc" block: W[16..79] match the golden model. With MOD_SCHED_ABORT_EN defined, ABORT at OUT_IDX=40 gives OUT_VALID=0 on the next cycle.
